// File: rtl/qrd_pkg.sv
// Shared constants and types for the QRD feed controller and its skew mapper.
package qrd_pkg;

  // Matrix dimension and the number of skewed beats needed for [H | I].
  localparam int N         = 4;
  localparam int NUM_BEATS = 2*N + N - 1;
  localparam int NUM_ELEMS = N*N;

  // Default sample width used by the complex sample type.
  localparam int SAMPLE_W  = 14;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    FEED     = 2'd1,
    WAIT_OUT = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/qrd_feed_ctrl_if.sv
// Bus bundle between the matrix source, the feed controller and the QRD core.
//
// Handshake rules:
//   - Input stream (s_*): an element transfers on a rising clk edge where
//     s_valid and s_ready are both 1. s_valid must not wait for s_ready, and
//     s_data_r/s_data_i must be stable while s_valid is 1.
//   - Core row inputs (row_in_*): the core takes the presented beat on a
//     rising clk edge where qrd_in_ready is 1. Otherwise the beat is held.
//   - qrd_out_valid is a level from the core; the first cycle it is seen
//     while waiting completes the matrix.
interface qrd_feed_ctrl_if #(
  parameter int IN_WIDTH = 14
);
  logic                       s_valid;
  logic                       s_ready;
  logic signed [IN_WIDTH-1:0] s_data_r;
  logic signed [IN_WIDTH-1:0] s_data_i;

  logic                       qrd_in_ready;
  logic                       qrd_out_valid;

  logic signed [IN_WIDTH-1:0] row_in_1_r;
  logic signed [IN_WIDTH-1:0] row_in_1_i;
  logic signed [IN_WIDTH-1:0] row_in_2_r;
  logic signed [IN_WIDTH-1:0] row_in_2_i;
  logic signed [IN_WIDTH-1:0] row_in_3_r;
  logic signed [IN_WIDTH-1:0] row_in_3_i;
  logic signed [IN_WIDTH-1:0] row_in_4_r;
  logic signed [IN_WIDTH-1:0] row_in_4_i;
  logic                       row_in_1_f;
  logic                       row_in_2_f;
  logic                       row_in_3_f;

  // Controller side: stream sink and core driver.
  modport slave (
    input  s_valid, s_data_r, s_data_i, qrd_in_ready, qrd_out_valid,
    output s_ready,
    output row_in_1_r, row_in_1_i, row_in_2_r, row_in_2_i,
    output row_in_3_r, row_in_3_i, row_in_4_r, row_in_4_i,
    output row_in_1_f, row_in_2_f, row_in_3_f
  );

  // Environment side: matrix source plus core model.
  modport master (
    output s_valid, s_data_r, s_data_i, qrd_in_ready, qrd_out_valid,
    input  s_ready,
    input  row_in_1_r, row_in_1_i, row_in_2_r, row_in_2_i,
    input  row_in_3_r, row_in_3_i, row_in_4_r, row_in_4_i,
    input  row_in_1_f, row_in_2_f, row_in_3_f
  );
endinterface

// File: rtl/qrd_skew_gen.sv
// Combinational map from beat index and H buffer to the four skewed row
// samples of the augmented matrix [H | I], plus first-beat flags.
module qrd_skew_gen
  import qrd_pkg::*;
#(
  parameter int IN_WIDTH = 14
) (
  input  logic        [3:0]          beat,
  input  logic signed [IN_WIDTH-1:0] h_r [NUM_ELEMS],
  input  logic signed [IN_WIDTH-1:0] h_i [NUM_ELEMS],
  output logic signed [IN_WIDTH-1:0] row_r [N],
  output logic signed [IN_WIDTH-1:0] row_i [N],
  output logic        [N-2:0]        row_f
);

  int         col;
  logic [3:0] idx;

  // Row k sees column (beat - k): H columns first, identity columns next, zero outside.
  always_comb begin
    col   = 0;
    idx   = '0;
    row_f = '0;
    for (int k = 0; k < N; k++) begin
      row_r[k] = '0;
      row_i[k] = '0;
      col      = int'(beat) - k;
      if (col >= 0 && col < N) begin
        idx      = 4'(k*N + col);
        row_r[k] = h_r[idx];
        row_i[k] = h_i[idx];
      end else if (col >= N && col < 2*N) begin
        if (col - N == k) begin
          row_r[k] = IN_WIDTH'(1);
        end
      end
    end
    for (int k = 0; k < N-1; k++) begin
      row_f[k] = (beat == 4'(k));
    end
  end

endmodule

// File: rtl/qrd_feed_ctrl.sv
// Feed controller for the 4x4 complex QRD core: loads H row-major, streams
// the skewed [H | I] beats under core back-pressure, then waits for the
// core result with a latency measurement and a sticky watchdog.
module qrd_feed_ctrl
  import qrd_pkg::*;
#(
  parameter int IN_WIDTH  = 14,
  parameter int TIMEOUT   = 1000,
  parameter int LAT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qrd_feed_ctrl_if.slave       bus,
  output logic                 busy,
  output logic                 done,
  output logic [LAT_WIDTH-1:0] last_latency,
  output logic                 timeout_err,
  output state_e               dbg_state
);

  state_e                     state_q, state_d;
  logic [3:0]                 elem_q;
  logic [3:0]                 beat_q;
  logic [3:0]                 beat_sel;
  logic [LAT_WIDTH-1:0]       lat_q;
  logic                       s_ready_q;

  logic signed [IN_WIDTH-1:0] h_r [NUM_ELEMS];
  logic signed [IN_WIDTH-1:0] h_i [NUM_ELEMS];

  logic signed [IN_WIDTH-1:0] skew_r [N];
  logic signed [IN_WIDTH-1:0] skew_i [N];
  logic        [N-2:0]        skew_f;
  logic signed [IN_WIDTH-1:0] out_r  [N];
  logic signed [IN_WIDTH-1:0] out_i  [N];
  logic        [N-2:0]        out_f;

  logic accept;
  logic beat_acc;
  logic last_elem;
  logic last_beat;
  logic timeout_hit;

  // s_ready_q is only ever 1 in LOAD, so a handshake implies LOAD.
  assign accept      = bus.s_valid && s_ready_q;
  assign beat_acc    = (state_q == FEED) && bus.qrd_in_ready;
  assign last_elem   = (elem_q == 4'(NUM_ELEMS-1));
  assign last_beat   = (beat_q == 4'(NUM_BEATS-1));
  // The increment on this cycle would make the counter reach TIMEOUT.
  assign timeout_hit = (lat_q == LAT_WIDTH'(TIMEOUT-1));

  assign bus.s_ready    = s_ready_q;
  assign bus.row_in_1_r = out_r[0];
  assign bus.row_in_1_i = out_i[0];
  assign bus.row_in_2_r = out_r[1];
  assign bus.row_in_2_i = out_i[1];
  assign bus.row_in_3_r = out_r[2];
  assign bus.row_in_3_i = out_i[2];
  assign bus.row_in_4_r = out_r[3];
  assign bus.row_in_4_i = out_i[3];
  assign bus.row_in_1_f = out_f[0];
  assign bus.row_in_2_f = out_f[1];
  assign bus.row_in_3_f = out_f[2];
  assign dbg_state      = state_q;

  qrd_skew_gen #(
    .IN_WIDTH (IN_WIDTH)
  ) u_skew (
    .beat  (beat_sel),
    .h_r   (h_r),
    .h_i   (h_i),
    .row_r (skew_r),
    .row_i (skew_i),
    .row_f (skew_f)
  );

  // Next state, status outputs and the beat to preload into the row registers.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    beat_sel = 4'd0;
    case (state_q)
      LOAD: begin
        if (accept && last_elem) begin
          state_d = FEED;
        end
      end
      FEED: begin
        busy     = 1'b1;
        beat_sel = beat_q + 4'd1;
        if (beat_acc && last_beat) begin
          state_d = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        busy = 1'b1;
        if (bus.qrd_out_valid) begin
          done    = 1'b1;
          state_d = LOAD;
        end else if (timeout_hit) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State, handshake ready, element and beat counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      s_ready_q <= 1'b0;
      elem_q    <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d == LOAD);
      if (accept) begin
        elem_q <= last_elem ? 4'd0 : elem_q + 4'd1;
      end
      if (state_q != FEED) begin
        beat_q <= '0;
      end else if (beat_acc) begin
        beat_q <= last_beat ? 4'd0 : beat_q + 4'd1;
      end
    end
  end

  // Row output registers: beat 0 on entry to FEED, next beat on each core accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        out_r[k] <= '0;
        out_i[k] <= '0;
      end
      out_f <= '0;
    end else if ((accept && last_elem) || (beat_acc && !last_beat)) begin
      out_r <= skew_r;
      out_i <= skew_i;
      out_f <= skew_f;
    end else if (beat_acc && last_beat) begin
      for (int k = 0; k < N; k++) begin
        out_r[k] <= '0;
        out_i[k] <= '0;
      end
      out_f <= '0;
    end
  end

  // Latency counter, latched latency and sticky watchdog error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q        <= '0;
      last_latency <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (state_q != WAIT_OUT) begin
        lat_q <= '0;
      end else if (lat_q != '1) begin
        lat_q <= lat_q + 1'b1;
      end
      if (state_q == WAIT_OUT && bus.qrd_out_valid) begin
        last_latency <= lat_q;
      end
      if (state_q == WAIT_OUT && !bus.qrd_out_valid && timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // H buffer holds data only; it is not cleared by reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      h_r[elem_q] <= bus.s_data_r;
      h_i[elem_q] <= bus.s_data_i;
    end
  end

endmodule

// File: tb/tb_qrd_feed_ctrl.sv
// Directed testbench for qrd_feed_ctrl with hand-computed beat tables.
module tb_qrd_feed_ctrl;
  import qrd_pkg::*;

  localparam int IN_W  = 14;
  localparam int LAT_W = 16;
  localparam int TMO   = 50;

  logic             clk;
  logic             rst_n;
  logic             busy;
  logic             done;
  logic [LAT_W-1:0] last_latency;
  logic             timeout_err;
  state_e           dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int cyc;
  int wcnt;
  int done_base;

  // Expected real/imag per beat (row 1..4) for H[r][c] = r*4+c+1, imag = -real.
  int exp_re [0:10][0:3] = '{
    '{1, 0, 0, 0}, '{2, 5, 0, 0}, '{3, 6, 9, 0}, '{4, 7, 10, 13},
    '{1, 8, 11, 14}, '{0, 0, 12, 15}, '{0, 1, 0, 16}, '{0, 0, 0, 0},
    '{0, 0, 1, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 1}};
  int exp_im [0:10][0:3] = '{
    '{-1, 0, 0, 0}, '{-2, -5, 0, 0}, '{-3, -6, -9, 0}, '{-4, -7, -10, -13},
    '{0, -8, -11, -14}, '{0, 0, -12, -15}, '{0, 0, 0, -16}, '{0, 0, 0, 0},
    '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};

  qrd_feed_ctrl_if #(.IN_WIDTH(IN_W)) ifc ();

  qrd_feed_ctrl #(
    .IN_WIDTH  (IN_W),
    .TIMEOUT   (TMO),
    .LAT_WIDTH (LAT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (ifc),
    .busy         (busy),
    .done         (done),
    .last_latency (last_latency),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL sim_timeout: got no end, expected finish");
    $fatal(1, "time limit");
  end

  // Handshake and done monitors.
  always @(posedge clk) if (ifc.s_valid && ifc.s_ready) acc_cnt++;
  always @(negedge clk) if (done) done_cnt++;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int row_re(input int k);
    case (k)
      0: return int'(ifc.row_in_1_r);
      1: return int'(ifc.row_in_2_r);
      2: return int'(ifc.row_in_3_r);
      default: return int'(ifc.row_in_4_r);
    endcase
  endfunction

  function automatic int row_im(input int k);
    case (k)
      0: return int'(ifc.row_in_1_i);
      1: return int'(ifc.row_in_2_i);
      2: return int'(ifc.row_in_3_i);
      default: return int'(ifc.row_in_4_i);
    endcase
  endfunction

  function automatic int row_fl(input int k);
    case (k)
      0: return int'(ifc.row_in_1_f);
      1: return int'(ifc.row_in_2_f);
      default: return int'(ifc.row_in_3_f);
    endcase
  endfunction

  task automatic check_rows_zero(input string tag);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("%s_r%0d_re", tag, k+1), row_re(k), 0);
      check_eq($sformatf("%s_r%0d_im", tag, k+1), row_im(k), 0);
    end
    for (int k = 0; k < 3; k++) check_eq($sformatf("%s_f%0d", tag, k+1), row_fl(k), 0);
  endtask

  // Drive H with element e = sgn*(e+1) - j*sgn*(e+1), optional one-cycle gaps.
  task automatic load_matrix(input int sgn, input bit gaps, input bit hold_valid);
    bit acc;
    int w;
    for (int e = 0; e < 16; e++) begin
      if (gaps && (e % 3 == 1)) begin
        ifc.s_valid = 1'b0;
        tick();
      end
      ifc.s_valid  = 1'b1;
      ifc.s_data_r = IN_W'(sgn*(e+1));
      ifc.s_data_i = IN_W'(-sgn*(e+1));
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 50) begin
        acc = ifc.s_ready;
        tick();
        w++;
      end
      if (!acc) check_eq($sformatf("load_e%0d_accept", e), 0, 1);
    end
    ifc.s_data_r = IN_W'(999);
    ifc.s_data_i = IN_W'(-999);
    if (!hold_valid) ifc.s_valid = 1'b0;
  endtask

  // Walk the beats, stalling stall_len cycles at stall_at; stop early at stop_at.
  task automatic feed_check(input int sgn, input int stall_at, input int stall_len,
                            input int stop_at, output int cycles);
    int b;
    int stalls;
    int s;
    b = 0;
    stalls = stall_len;
    cycles = 0;
    while (b <= 10 && cycles < 40) begin
      for (int k = 0; k < 4; k++) begin
        s = (exp_im[b][k] != 0) ? sgn : 1;
        check_eq($sformatf("b%0d_r%0d_re", b, k+1), row_re(k), s*exp_re[b][k]);
        check_eq($sformatf("b%0d_r%0d_im", b, k+1), row_im(k), s*exp_im[b][k]);
      end
      for (int k = 0; k < 3; k++)
        check_eq($sformatf("b%0d_f%0d", b, k+1), row_fl(k), (b == k) ? 1 : 0);
      if (b == stop_at) return;
      if (b == stall_at && stalls > 0) begin
        ifc.qrd_in_ready = 1'b0;
        stalls--;
      end else begin
        ifc.qrd_in_ready = 1'b1;
        b++;
      end
      tick();
      cycles++;
    end
    ifc.qrd_in_ready = 1'b0;
    check_eq("feed_len", cycles, 11 + stall_len);
    check_rows_zero("post_feed");
    check_eq("wait_busy", int'(busy), 1);
    check_eq("wait_state", int'(dbg_state), int'(WAIT_OUT));
  endtask

  // Assert qrd_out_valid 'delay' cycles after WAIT_OUT entry and check completion.
  task automatic wait_out(input int delay);
    int base;
    base = done_cnt;
    repeat (delay) tick();
    ifc.qrd_out_valid = 1'b1;
    #1;
    check_eq("done_pulse", int'(done), 1);
    tick();
    ifc.qrd_out_valid = 1'b0;
    check_eq("done_count", done_cnt - base, 1);
    check_eq("last_latency", int'(last_latency), delay);
    check_eq("ready_after_done", int'(ifc.s_ready), 1);
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_state", int'(dbg_state), int'(LOAD));
  endtask

  initial begin
    rst_n             = 1'b0;
    ifc.s_valid       = 1'b0;
    ifc.s_data_r      = '0;
    ifc.s_data_i      = '0;
    ifc.qrd_in_ready  = 1'b0;
    ifc.qrd_out_valid = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_s_ready", int'(ifc.s_ready), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_tmo", int'(timeout_err), 0);
    check_eq("rst_lat", int'(last_latency), 0);
    check_eq("rst_state", int'(dbg_state), int'(LOAD));
    check_rows_zero("rst");
    rst_n = 1'b1;
    tick();
    check_eq("load_s_ready", int'(ifc.s_ready), 1);

    // Plain load, stall-free feed, result after 20 cycles.
    load_matrix(1, 1'b0, 1'b0);
    feed_check(1, -1, 0, 99, cyc);
    wait_out(20);

    // Gapped valid held high through FEED/WAIT_OUT, 3-cycle stall at beat 5.
    acc_cnt = 0;
    load_matrix(1, 1'b1, 1'b1);
    feed_check(1, 5, 3, 99, cyc);
    wait_out(7);
    ifc.s_valid = 1'b0;
    check_eq("accept_count", acc_cnt, 16);

    // Core never answers: watchdog after TMO cycles.
    done_base = done_cnt;
    load_matrix(1, 1'b0, 1'b0);
    feed_check(1, -1, 0, 99, cyc);
    wcnt = 0;
    while (busy && wcnt < 200) begin
      wcnt++;
      tick();
    end
    check_eq("tmo_wait_cycles", wcnt, TMO);
    check_eq("tmo_err", int'(timeout_err), 1);
    check_eq("tmo_no_done", done_cnt - done_base, 0);
    check_eq("tmo_lat_kept", int'(last_latency), 7);
    check_eq("tmo_state", int'(dbg_state), int'(LOAD));

    // A different matrix still feeds after the timeout; error stays sticky.
    load_matrix(-1, 1'b0, 1'b0);
    feed_check(-1, -1, 0, 99, cyc);
    wait_out(3);
    check_eq("tmo_sticky", int'(timeout_err), 1);

    // Reset pulse mid-FEED at beat 6.
    load_matrix(1, 1'b0, 1'b0);
    feed_check(1, -1, 0, 6, cyc);
    rst_n = 1'b0;
    #1;
    check_rows_zero("async_rst");
    check_eq("async_rst_busy", int'(busy), 0);
    check_eq("async_rst_ready", int'(ifc.s_ready), 0);
    check_eq("async_rst_tmo", int'(timeout_err), 0);
    check_eq("async_rst_state", int'(dbg_state), int'(LOAD));
    ifc.qrd_in_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_ready", int'(ifc.s_ready), 1);
    load_matrix(-1, 1'b0, 1'b0);
    feed_check(-1, -1, 0, 99, cyc);
    wait_out(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
